// File: rtl/laser_cannon_pkg.sv
// rtl/laser_cannon_pkg.sv - shared game geometry, colour codes and laser FSM states
package laser_cannon_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SHIP_HEIGHT   = 30;
    localparam int V_OFFSET      = 10;

    localparam logic [2:0] NONE       = 3'd7;
    localparam logic [2:0] BACKGROUND = 3'd0;
    localparam logic [2:0] SPACESHIP  = 3'd1;
    localparam logic [2:0] ALIENS0    = 3'd2;
    localparam logic [2:0] ALIENS1    = 3'd3;
    localparam logic [2:0] ALIENS2    = 3'd4;
    localparam logic [2:0] ALIENS3    = 3'd5;
    localparam logic [2:0] LASER      = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

endpackage

// File: rtl/laser_cannon_move_tick_gen.sv
// rtl/laser_cannon_move_tick_gen.sv - free-running divider pulsing one move tick every MOVE_DIV cycles
module move_tick_gen #(
    parameter int MOVE_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(MOVE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/laser_cannon.sv
// rtl/laser_cannon.sv - player laser bolt: launch on fire edge, climb per move tick, stop on hit or top exit
module laser_cannon
    import laser_cannon_pkg::*;
#(
    parameter int SCREEN_WIDTH   = laser_cannon_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT  = laser_cannon_pkg::SCREEN_HEIGHT,
    parameter int SHIP_HEIGHT    = laser_cannon_pkg::SHIP_HEIGHT,
    parameter int V_OFFSET       = laser_cannon_pkg::V_OFFSET,
    parameter int LASER_WIDTH    = 4,
    parameter int LASER_HEIGHT   = 12,
    parameter int LASER_STEP     = 8,
    parameter int MOVE_DIV       = 100000,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       hit,
    output logic [9:0] laserX,
    output logic [9:0] laserY,
    output logic       active,
    output logic [2:0] color
);

    localparam logic [9:0] LAUNCH_Y = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - LASER_HEIGHT);
    localparam int         HALF_W   = LASER_WIDTH / 2;
    localparam int         CDW      = $clog2(COOLDOWN_TICKS) + 1;

    state_t         state, next_state;
    logic           fire_q;
    logic           fire_edge;
    logic           tick;
    logic           launch, stop, move, cd_done;
    logic [CDW-1:0] cd_cnt;

    assign fire_edge = fire & ~fire_q;

    move_tick_gen #(
        .MOVE_DIV(MOVE_DIV)
    ) u_move_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(launch),
        .tick (tick)
    );

    // hit outranks a coincident tick; the step guard keeps laserY from underflowing
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        stop       = 1'b0;
        move       = 1'b0;
        cd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (fire_edge) begin
                    launch     = 1'b1;
                    next_state = FLY;
                end
            end
            FLY: begin
                if (hit) begin
                    stop       = 1'b1;
                    next_state = COOLDOWN;
                end else if (tick) begin
                    if (laserY > 10'(LASER_STEP)) begin
                        move = 1'b1;
                    end else begin
                        stop       = 1'b1;
                        next_state = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (tick && (cd_cnt == CDW'(COOLDOWN_TICKS - 1))) begin
                    cd_done    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            fire_q <= 1'b1;
            laserX <= '0;
            laserY <= '0;
            active <= 1'b0;
            cd_cnt <= '0;
        end else begin
            state  <= next_state;
            fire_q <= fire;
            if (launch) begin
                laserX <= gunPosition;
                laserY <= LAUNCH_Y;
                active <= 1'b1;
            end
            if (move) begin
                laserY <= laserY - 10'(LASER_STEP);
            end
            if (stop) begin
                active <= 1'b0;
                cd_cnt <= '0;
            end else if (state == COOLDOWN && tick) begin
                cd_cnt <= cd_done ? '0 : cd_cnt + CDW'(1);
            end
        end
    end

    // bounds widened to 11 bits so the edges of the bolt cannot wrap around
    logic [10:0] h_ext, v_ext, x_ext, y_ext;
    logic        in_h, in_v, visible;

    always_comb begin
        h_ext   = {1'b0, hPos};
        v_ext   = {1'b0, vPos};
        x_ext   = {1'b0, laserX};
        y_ext   = {1'b0, laserY};
        in_h    = (h_ext + 11'(HALF_W) >= x_ext) && (h_ext <= x_ext + 11'(HALF_W - 1));
        in_v    = (v_ext >= y_ext) && (v_ext <= y_ext + 11'(LASER_HEIGHT - 1));
        visible = (h_ext < 11'(SCREEN_WIDTH)) && (v_ext < 11'(SCREEN_HEIGHT));
        color   = (active && in_h && in_v && visible) ? LASER : BACKGROUND;
    end

endmodule
